// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared IF/LS memory port sequencer for the multi-cycle RV32 core
//
// Purpose: arbitrates instruction fetch (IF) and load/store (LS) requests onto a
// single req/gnt/rvalid memory bus, one outstanding transaction at a time, and
// converts the one-hot LS info code into byte enables, lane-replicated write
// data and extended load data.
//
// Optional feature: define MEM_ARB_RR_EN for round-robin IF/LS arbitration;
// undefined gives fixed LS-over-IF priority.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   if_req_i/if_addr_i                 fetch request (level) and word address
//   if_gnt_o/if_rvalid_o/if_rdata_o    fetch accept pulse, completion pulse, instruction
//   ls_req_i/ls_info_i/ls_addr_i/ls_wdata_i  LS request, one-hot op, byte address, store data
//   ls_gnt_o/ls_rvalid_o/ls_rdata_o/ls_err_o LS accept, completion, load data, misalign error
//   mem_req_o/mem_we_o/mem_addr_o/mem_be_o/mem_wdata_o  bus request side
//   mem_gnt_i/mem_rvalid_i/mem_rdata_i bus accept and response
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic [7:0]        ls_info_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              ls_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = LS owns the transaction
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          info_q, info_d;     // one-hot after priority reduction
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                ls_valid;
  logic [7:0]          info_pri;
  logic                ls_misaligned;
  logic                grant_ls, grant_if;
  logic                is_b, is_h, is_st;
  logic [DATA_W-1:0]   shifted;

  // An LS request with an empty info code is not a request at all.
  assign ls_valid = ls_req_i && (ls_info_i != 8'h00);

  // Highest set info bit wins when several are set.
  always_comb begin
    info_pri = 8'h00;
    casez (ls_info_i)
      8'b1???????: info_pri = 8'b1000_0000;
      8'b01??????: info_pri = 8'b0100_0000;
      8'b001?????: info_pri = 8'b0010_0000;
      8'b0001????: info_pri = 8'b0001_0000;
      8'b00001???: info_pri = 8'b0000_1000;
      8'b000001??: info_pri = 8'b0000_0100;
      8'b0000001?: info_pri = 8'b0000_0010;
      8'b00000001: info_pri = 8'b0000_0001;
      default:     info_pri = 8'h00;
    endcase
  end

  assign ls_misaligned = ((info_pri[6] | info_pri[3] | info_pri[1]) && ls_addr_i[0]) ||
                         ((info_pri[5] | info_pri[0]) && (ls_addr_i[1:0] != 2'b00));

`ifdef MEM_ARB_RR_EN
  logic last_ls_q, last_ls_d;  // 1 = LS was granted last; reset means "IF last"
  assign grant_ls = (state_q == S_IDLE) && ls_valid && (!if_req_i || !last_ls_q);
  assign grant_if = (state_q == S_IDLE) && if_req_i && !grant_ls;
  always_comb begin
    last_ls_d = last_ls_q;
    if (grant_ls)      last_ls_d = 1'b1;
    else if (grant_if) last_ls_d = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_ls_q <= 1'b0;
    else        last_ls_q <= last_ls_d;
  end
`else
  assign grant_ls = (state_q == S_IDLE) && ls_valid;
  assign grant_if = (state_q == S_IDLE) && if_req_i && !ls_valid;
`endif

  assign ls_gnt_o = grant_ls;
  assign if_gnt_o = grant_if;

  // Fetches latch info 0, so they decode as full-word reads.
  assign is_b    = info_q[7] | info_q[4] | info_q[2];
  assign is_h    = info_q[6] | info_q[3] | info_q[1];
  assign is_st   = info_q[2] | info_q[1] | info_q[0];
  assign shifted = mem_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    info_d  = info_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_ls) begin
          owner_d = 1'b1;
          addr_d  = ls_addr_i;
          info_d  = info_pri;
          wdata_d = ls_wdata_i;
          rdata_d = '0;
          err_d   = ls_misaligned;
          state_d = ls_misaligned ? S_DONE : S_ISSUE;
        end else if (grant_if) begin
          owner_d = 1'b0;
          addr_d  = if_addr_i;
          info_d  = 8'h00;
          wdata_d = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (mem_gnt_i) state_d = S_WAIT;
      S_WAIT: begin
        if (mem_rvalid_i) begin
          state_d = S_DONE;
          if (!owner_q)       rdata_d = mem_rdata_i;
          else if (info_q[7]) rdata_d = {{24{shifted[7]}}, shifted[7:0]};
          else if (info_q[6]) rdata_d = {{16{shifted[15]}}, shifted[15:0]};
          else if (info_q[5]) rdata_d = mem_rdata_i;
          else if (info_q[4]) rdata_d = {24'h0, shifted[7:0]};
          else if (info_q[3]) rdata_d = {16'h0, shifted[15:0]};
          else                rdata_d = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      info_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      info_q  <= info_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus fields are only driven while requesting; they come straight from
  // latched state so they stay stable through an unbounded gnt stall.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = 4'b0000;
    mem_wdata_o = '0;
    if (state_q == S_ISSUE) begin
      mem_req_o  = 1'b1;
      mem_we_o   = is_st;
      mem_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
      if (is_b) begin
        mem_be_o    = 4'b0001 << addr_q[1:0];
        mem_wdata_o = {4{wdata_q[7:0]}};
      end else if (is_h) begin
        mem_be_o    = addr_q[1] ? 4'b1100 : 4'b0011;
        mem_wdata_o = {2{wdata_q[15:0]}};
      end else begin
        mem_be_o    = 4'b1111;
        mem_wdata_o = wdata_q;
      end
    end
  end

  assign if_rvalid_o = (state_q == S_DONE) && !owner_q;
  assign if_rdata_o  = if_rvalid_o ? rdata_q : '0;
  assign ls_rvalid_o = (state_q == S_DONE) && owner_q;
  assign ls_err_o    = ls_rvalid_o && err_q;
  assign ls_rdata_o  = ls_rvalid_o ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed table-driven bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i = 1'b0;
  logic [7:0]  ls_info_i = '0;
  logic [31:0] ls_addr_i = '0;
  logic [31:0] ls_wdata_i = '0;
  logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_info_i(ls_info_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic [7:0]  info;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
    logic        err;
    logic        we;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam logic [7:0] LB = 8'h80, LH = 8'h40, LW = 8'h20, LBU = 8'h10;
  localparam logic [7:0] LHU = 8'h08, SB = 8'h04, SH = 8'h02, SW = 8'h01;

  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mem_req"}, {31'h0, mem_req_o}, 32'h0);
    chk({tag, "_mem_fields"}, {mem_addr_o | mem_wdata_o | {28'h0, mem_be_o} | {31'h0, mem_we_o}}, 32'h0);
    chk({tag, "_rvalid"}, {30'h0, ls_rvalid_o, if_rvalid_o}, 32'h0);
    chk({tag, "_ls_out"}, ls_rdata_o | {31'h0, ls_err_o}, 32'h0);
    chk({tag, "_if_rdata"}, if_rdata_o, 32'h0);
  endtask

  // Runs one LS transaction; entered and left at a negedge with the DUT idle.
  task automatic do_ls(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    ls_req_i = 1'b1; ls_info_i = v.info; ls_addr_i = v.addr; ls_wdata_i = v.wdata;
    #1;
    chk($sformatf("v%0d_gnt", i), {31'h0, ls_gnt_o}, 32'h1);
    @(negedge clk);
    ls_req_i = 1'b0; ls_info_i = '0;
    #1;
    if (v.err) begin
      chk($sformatf("v%0d_err_noreq", i), {31'h0, mem_req_o}, 32'h0);
      chk($sformatf("v%0d_err_rvalid", i), {30'h0, ls_rvalid_o, ls_err_o}, 32'h3);
      chk($sformatf("v%0d_err_rdata", i), ls_rdata_o, 32'h0);
    end else begin
      for (int s = 0; s <= v.stall; s++) begin
        chk($sformatf("v%0d_req_c%0d", i, s), {31'h0, mem_req_o}, 32'h1);
        chk($sformatf("v%0d_addr_c%0d", i, s), mem_addr_o, v.maddr);
        chk($sformatf("v%0d_be_c%0d", i, s), {28'h0, mem_be_o}, {28'h0, v.be});
        chk($sformatf("v%0d_we_c%0d", i, s), {31'h0, mem_we_o}, {31'h0, v.we});
        if (v.we) chk($sformatf("v%0d_wdata_c%0d", i, s), mem_wdata_o, v.mwdata);
        if (s == v.stall) mem_gnt_i = 1'b1;
        @(negedge clk); #1;
      end
      mem_gnt_i = 1'b0;
      chk($sformatf("v%0d_req_after_gnt", i), {31'h0, mem_req_o}, 32'h0);
      mem_rvalid_i = 1'b1; mem_rdata_i = v.rdata;
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      #1;
      chk($sformatf("v%0d_rvalid", i), {30'h0, ls_rvalid_o, ls_err_o}, 32'h2);
      chk($sformatf("v%0d_rdata", i), ls_rdata_o, v.exp_rdata);
    end
    @(negedge clk); #1;
    chk($sformatf("v%0d_rvalid_one", i), {31'h0, ls_rvalid_o}, 32'h0);
  endtask

  initial begin
    logic exp_ls;
    int   cyc;

    //          info      addr        wdata         rdata        stl err we  be       maddr       mwdata        exp_rdata
    vecs[0]  = '{LW,      32'h100, 32'h0,        32'hDEADBEEF, 2, 0, 0, 4'b1111, 32'h100, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{LB,      32'h203, 32'h0,        32'h80112233, 0, 0, 0, 4'b1000, 32'h200, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{LBU,     32'h203, 32'h0,        32'h80112233, 1, 0, 0, 4'b1000, 32'h200, 32'h0,        32'h00000080};
    vecs[3]  = '{SH,      32'h302, 32'h0000ABCD, 32'h55555555, 0, 0, 1, 4'b1100, 32'h300, 32'hABCDABCD, 32'h0};
    vecs[4]  = '{SW,      32'h401, 32'h11111111, 32'h0,        0, 1, 0, 4'b0000, 32'h0,   32'h0,        32'h0};
    vecs[5]  = '{LH,      32'h202, 32'h0,        32'h80112233, 0, 0, 0, 4'b1100, 32'h200, 32'h0,        32'hFFFF8011};
    vecs[6]  = '{LHU,     32'h200, 32'h0,        32'h80118233, 0, 0, 0, 4'b0011, 32'h200, 32'h0,        32'h00008233};
    vecs[7]  = '{SB,      32'h101, 32'h12345678, 32'h0,        3, 0, 1, 4'b0010, 32'h100, 32'h78787878, 32'h0};
    vecs[8]  = '{LH,      32'h201, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,   32'h0,        32'h0};
    vecs[9]  = '{LB | SW, 32'h203, 32'h0,        32'h80112233, 0, 0, 0, 4'b1000, 32'h200, 32'h0,        32'hFFFFFF80};
    vecs[10] = '{SW,      32'h404, 32'hCAFEF00D, 32'h0,        0, 0, 1, 4'b1111, 32'h404, 32'hCAFEF00D, 32'h0};
    vecs[11] = '{LW,      32'h402, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,   32'h0,        32'h0};

    repeat (2) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset_gnt", {30'h0, if_gnt_o, ls_gnt_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) do_ls(i);

    // Empty info code is not a request.
    @(negedge clk);
    ls_req_i = 1'b1; ls_info_i = 8'h00; ls_addr_i = 32'h500;
    #1;
    chk("info0_gnt", {31'h0, ls_gnt_o}, 32'h0);
    @(negedge clk); #1;
    chk("info0_noreq", {31'h0, mem_req_o}, 32'h0);
    ls_req_i = 1'b0;

    // Plain fetch.
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'h40;
    #1;
    chk("if_gnt", {31'h0, if_gnt_o}, 32'h1);
    @(negedge clk);
    if_req_i = 1'b0; mem_gnt_i = 1'b1;
    #1;
    chk("if_addr", mem_addr_o, 32'h40);
    chk("if_be_we", {27'h0, mem_be_o, mem_we_o}, {27'h0, 4'b1111, 1'b0});
    @(negedge clk);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00000013;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #1;
    chk("if_rvalid", {30'h0, if_rvalid_o, ls_rvalid_o}, 32'h2);
    chk("if_rdata", if_rdata_o, 32'h00000013);
    @(negedge clk); #1;
    chk("if_rvalid_one", {31'h0, if_rvalid_o}, 32'h0);

    // Both requesters held high across four transactions.
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'h80;
    ls_req_i = 1'b1; ls_info_i = LW; ls_addr_i = 32'h10;
    #1;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_ls = (k % 2 == 0);
`else
      exp_ls = 1'b1;
`endif
      cyc = 0;
      while (!(if_gnt_o || ls_gnt_o) && cyc < 10) begin
        @(negedge clk); #1; cyc++;
      end
      chk($sformatf("arb%0d_gnt", k), {30'h0, ls_gnt_o, if_gnt_o}, {30'h0, exp_ls, !exp_ls});
      @(negedge clk);
      mem_gnt_i = 1'b1;
      #1;
      chk($sformatf("arb%0d_addr", k), mem_addr_o, exp_ls ? 32'h10 : 32'h80);
      @(negedge clk);
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA5A50000 + k;
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      #1;
      chk($sformatf("arb%0d_done_nognt", k), {30'h0, if_gnt_o, ls_gnt_o}, 32'h0);
      chk($sformatf("arb%0d_rvalid", k), {30'h0, ls_rvalid_o, if_rvalid_o}, {30'h0, exp_ls, !exp_ls});
      @(negedge clk); #1;
    end
    if_req_i = 1'b0; ls_req_i = 1'b0; ls_info_i = '0;

    // Reset during WAIT, followed by stray responses.
    @(negedge clk);
    ls_req_i = 1'b1; ls_info_i = LW; ls_addr_i = 32'h100;
    @(negedge clk);
    ls_req_i = 1'b0; ls_info_i = '0; mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("rstwait");
    @(negedge clk);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBADBAD00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #1;
    chk_idle_outputs("rstlate");
    do_ls(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
